// File: rtl/seq_alu.sv
// seq_alu: registered N-bit signed ALU with valid/ready handshakes on both sides.
// Non-multiply operations complete in one cycle. MUL runs an N-step shift-add on the
// operand magnitudes and fixes the sign at the end. One operation is in flight at a time.
// The result is held in DONE until the sink takes it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   a, b, opcode      signed operands and operation select
//   out_valid/out_ready result handshake; out_valid is high only in DONE
//   out, zero, neg    2N-bit signed result and its flags, registered together
module seq_alu #(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned W    = 2 * N;
  localparam int unsigned CntW = $clog2(N);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpXor = 3'b101;
  localparam logic [2:0] OpSra = 3'b110;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    out_q, out_d;
  logic            zero_q, zero_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    mcand_q, mcand_d;   // |a|, shifted left each step
  logic [N-1:0]    mplier_q, mplier_d; // |b|, shifted right each step
  logic [W-1:0]    acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sign_q, sign_d;

  logic [W-1:0]    a_ext, b_ext;
  logic [N-1:0]    a_abs, b_abs;
  logic [N-1:0]    sh;
  logic [W-1:0]    alu_res;
  logic [W-1:0]    acc_step;
  logic [W-1:0]    prod;
  logic            res_wr;
  logic [W-1:0]    res_val;

  // Single-cycle datapath
  always_comb begin
    a_ext   = {{N{a[N-1]}}, a};
    b_ext   = {{N{b[N-1]}}, b};
    // Shifting by 2N-1 already yields all sign bits; larger amounts saturate.
    sh      = (b > N'(W - 1)) ? N'(W - 1) : b;
    alu_res = '0;
    case (opcode)
      OpAdd:   alu_res = a_ext + b_ext;
      OpSub:   alu_res = a_ext - b_ext;
      OpAnd:   alu_res = {{N{1'b0}}, a & b};
      OpOr:    alu_res = {{N{1'b0}}, a | b};
      OpXor:   alu_res = {{N{1'b0}}, a ^ b};
      OpSra:   alu_res = $signed(a_ext) >>> sh;
      default: alu_res = '0;
    endcase
  end

  // Magnitudes fit in N unsigned bits, including 2^(N-1) for the most negative input.
  always_comb begin
    a_abs    = a[N-1] ? (~a + N'(1)) : a;
    b_abs    = b[N-1] ? (~b + N'(1)) : b;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod     = sign_q ? (~acc_step + W'(1)) : acc_step;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    res_wr   = 1'b0;
    res_val  = alu_res;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (opcode == OpMul) begin
            mcand_d  = {{N{1'b0}}, a_abs};
            mplier_d = b_abs;
            acc_d    = '0;
            cnt_d    = '0;
            sign_d   = a[N-1] ^ b[N-1];
            state_d  = StMul;
          end else begin
            res_wr  = 1'b1;
            res_val = alu_res;
            state_d = StDone;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          res_wr  = 1'b1;
          res_val = prod;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    out_d  = res_wr ? res_val : out_q;
    zero_d = res_wr ? (res_val == '0) : zero_q;
    neg_d  = res_wr ? res_val[W-1] : neg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      out_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
    end
  end

  assign out  = out_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed N=4 vectors plus an N=8 randomised sweep.
// Expected results are queued at issue time; monitors pop them on each output handshake.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic sweep_done = 1'b0;

  // N=4 instance
  logic       rst4_n, in_valid4, in_ready4, out_valid4, out_ready4, zero4, neg4;
  logic [3:0] a4, b4;
  logic [2:0] op4;
  logic [7:0] out4;

  seq_alu #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .opcode(op4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out(out4), .zero(zero4), .neg(neg4)
  );

  // N=8 instance
  logic        rst8_n, in_valid8, in_ready8, out_valid8, out_ready8, zero8, neg8;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic [15:0] out8;

  seq_alu #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .opcode(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .zero(zero8), .neg(neg8)
  );

  // Entries are {out, zero, neg}
  logic [9:0]  exp4_q[$];
  logic [17:0] exp8_q[$];
  logic [9:0]  e4;
  logic [17:0] e8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model for the sweep, written with plain integer arithmetic.
  function automatic logic [15:0] ref8(input logic [2:0] op, input logic [7:0] x,
                                        input logic [7:0] y);
    longint sx, sy, r;
    int     shamt;
    sx = $signed(x);
    sy = $signed(y);
    shamt = (y > 8'd15) ? 15 : int'(y);
    case (op)
      3'd0:    r = sx + sy;
      3'd1:    r = sx - sy;
      3'd2:    r = sx * sy;
      3'd3:    r = longint'(x & y);
      3'd4:    r = longint'(x | y);
      3'd5:    r = longint'(x ^ y);
      3'd6:    r = sx >>> shamt;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst4_n && out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL n4 unexpected result: got %0h, expected no result", out4);
      end else begin
        e4 = exp4_q.pop_front();
        chk("n4 out", out4, e4[9:2]);
        chk("n4 zero", zero4, e4[1]);
        chk("n4 neg", neg4, e4[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst8_n && out_valid8 && out_ready8) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL n8 unexpected result: got %0h, expected no result", out8);
      end else begin
        e8 = exp8_q.pop_front();
        chk("n8 out", out8, e8[17:2]);
        chk("n8 zero", zero8, e8[1]);
        chk("n8 neg", neg8, e8[0]);
      end
    end
  end

  initial begin
    out_ready8 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready8 = sweep_done ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Issue one N=4 operation, check latency and busy behaviour, optionally hold off the sink.
  task automatic issue4(input string name, input logic [2:0] op, input logic [3:0] xa,
                        input logic [3:0] xb, input logic [7:0] expv, input int lat,
                        input int hold);
    int cyc;
    chk({name, " ready before"}, in_ready4, 1);
    a4 = xa;
    b4 = xb;
    op4 = op;
    in_valid4 = 1'b1;
    out_ready4 = 1'b0;
    exp4_q.push_back({expv, expv == 8'h00, expv[7]});
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    cyc = 1;
    while (!out_valid4 && cyc < 20) begin
      chk({name, " busy in_ready"}, in_ready4, 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, " latency"}, cyc, lat);
    chk({name, " done in_ready"}, in_ready4, 0);
    for (int i = 0; i < hold; i++) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      op4 = 3'($urandom);
      in_valid4 = 1'b1;
      @(posedge clk);
      #1;
      chk({name, " hold out"}, out4, expv);
      chk({name, " hold zero"}, zero4, expv == 8'h00);
      chk({name, " hold neg"}, neg4, expv[7]);
      chk({name, " hold valid"}, out_valid4, 1);
      chk({name, " hold in_ready"}, in_ready4, 0);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
    chk({name, " idle after handshake"}, in_ready4, 1);
    chk({name, " valid after handshake"}, out_valid4, 0);
  endtask

  initial begin
    int n;
    logic acc;
    rst4_n = 1'b0;
    rst8_n = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; op4 = '0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    #12;
    chk("reset out", out4, 0);
    chk("reset out_valid", out_valid4, 0);
    chk("reset zero", zero4, 0);
    chk("reset neg", neg4, 0);
    rst4_n = 1'b1;
    rst8_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", in_ready4, 1);

    issue4("add 7+7", 3'b000, 4'd7, 4'd7, 8'd14, 1, 0);
    issue4("sub -8-7", 3'b001, 4'h8, 4'd7, 8'hF1, 1, 0);
    issue4("mul -8*-8", 3'b010, 4'h8, 4'h8, 8'h40, 5, 0);
    issue4("mul -8*7", 3'b010, 4'h8, 4'd7, 8'hC8, 5, 0);
    issue4("mul 0*-3", 3'b010, 4'h0, 4'hD, 8'h00, 5, 0);
    issue4("and", 3'b011, 4'b1010, 4'b0110, 8'h02, 1, 0);
    issue4("or", 3'b100, 4'b1010, 4'b0110, 8'h0E, 1, 0);
    issue4("xor", 3'b101, 4'b1010, 4'b0110, 8'h0C, 1, 0);
    issue4("sra -8>>>1", 3'b110, 4'h8, 4'd1, 8'hFC, 1, 0);
    issue4("sra -8>>>7", 3'b110, 4'h8, 4'd7, 8'hFF, 1, 0);
    issue4("sra 7>>>15", 3'b110, 4'd7, 4'hF, 8'h00, 1, 0);
    issue4("reserved", 3'b111, 4'd5, 4'd3, 8'h00, 1, 0);
    issue4("backpressure add", 3'b000, 4'd3, 4'd4, 8'h07, 1, 10);

    // Reset during the second cycle of a multiply: nothing may come out of it.
    a4 = 4'd3; b4 = 4'd5; op4 = 3'b010; in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    @(posedge clk);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("mid-mul reset out_valid", out_valid4, 0);
    chk("mid-mul reset out", out4, 0);
    @(posedge clk);
    #1;
    rst4_n = 1'b1;
    chk("in_ready after mid-mul reset", in_ready4, 1);
    issue4("add 1+1 after reset", 3'b000, 4'd1, 4'd1, 8'd2, 1, 0);
    chk("n4 queue empty", exp4_q.size(), 0);

    // N=8 sweep with random gaps on both sides.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [7:0] x, y;
      if (i == 0) begin
        op = 3'b010; x = 8'h80; y = 8'h80;
      end else begin
        op = 3'($urandom);
        x = 8'($urandom);
        y = (op == 3'b110 && i[0]) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      a8 = x; b8 = y; op8 = op; in_valid8 = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
        acc = in_ready8;
        if (acc) begin
          e8[17:2] = ref8(op, x, y);
          exp8_q.push_back({e8[17:2], e8[17:2] == 16'h0, e8[17]});
        end
        @(posedge clk);
        #1;
        n++;
      end
      in_valid8 = 1'b0;
      chk("n8 accepted", acc, 1);
      if (i == 0) chk("n8 ref -128*-128", ref8(3'b010, 8'h80, 8'h80), 16'd16384);
    end
    sweep_done = 1'b1;
    n = 0;
    while ((exp8_q.size() != 0 || out_valid8) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("n8 queue drained", exp8_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
